// File: rtl/pe_config_loader_pkg.sv
// Shared types and constants for the PE configuration loader.
// Header word layout, loader FSM states and the PE instruction encodings.
package pe_cfg_pkg;

  typedef enum logic [1:0] {HDR, LOAD, DRAIN} cfg_state_e;

  typedef struct packed {
    logic       bcast;
    logic [6:0] rsvd_hi;
    logic [7:0] count;
    logic [7:0] first;
    logic [3:0] rsvd_lo;
    logic [3:0] instr;
  } cfg_hdr_t;

  // Bit positions of the header fields
  localparam int HDR_INSTR_LSB   = 0;
  localparam int HDR_RSVD_LO_LSB = 4;
  localparam int HDR_FIRST_LSB   = 8;
  localparam int HDR_COUNT_LSB   = 16;
  localparam int HDR_RSVD_HI_LSB = 24;
  localparam int HDR_BCAST_BIT   = 31;

  // PE instruction encodings (passed through untouched by the loader)
  localparam logic [3:0] FADD        = 4'b0000;
  localparam logic [3:0] FMUL        = 4'b0001;
  localparam logic [3:0] WEIGHT_ONLY = 4'b0010;
  localparam logic [3:0] FMA         = 4'b0011;
  localparam logic [3:0] SYS_FMA     = 4'b1010;

  // Split a raw packet word into header fields
  function automatic cfg_hdr_t hdr_decode(input logic [31:0] w);
    cfg_hdr_t h;
    h.instr   = w[HDR_INSTR_LSB   +: 4];
    h.rsvd_lo = w[HDR_RSVD_LO_LSB +: 4];
    h.first   = w[HDR_FIRST_LSB   +: 8];
    h.count   = w[HDR_COUNT_LSB   +: 8];
    h.rsvd_hi = w[HDR_RSVD_HI_LSB +: 7];
    h.bcast   = w[HDR_BCAST_BIT];
    return h;
  endfunction

endpackage

// File: rtl/pe_config_loader_if.sv
// Valid/ready configuration packet stream feeding the PE config loader.
interface pe_config_loader_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/pe_load_decoder.sv
// Turns the current PE index (or a broadcast range) into a per-PE load mask.
module pe_load_decoder #(
  parameter int NUM_PE = 16,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [7:0]        first,
  input  logic [7:0]        count,
  input  logic              bcast,
  output logic [NUM_PE-1:0] mask
);

  logic [8:0] first_ext;
  logic [8:0] range_end;

  assign first_ext = {1'b0, first};
  assign range_end = {1'b0, first} + {1'b0, count};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
      localparam logic [8:0]       PE_POS = 9'(gi);
      localparam logic [IDX_W-1:0] PE_IDX = IDX_W'(gi);
      assign mask[gi] = bcast ? ((first_ext <= PE_POS) && (PE_POS < range_end))
                              : (idx == PE_IDX);
    end
  endgenerate

endmodule

// File: rtl/pe_config_loader.sv
// Switch-side PE programming engine: parses header + data packets and drives
// registered per-PE load strobes with a shared instruction/data bus.
// Optional build macro: PE_CFG_BROADCAST_EN (header bit31 loads a PE range
// with a single word); when undefined, bit31 set is a header error.
module pe_config_loader
  import pe_cfg_pkg::*;
#(
  parameter int NUM_PE = 16
) (
  input  logic               clk,
  input  logic               reset,
  pe_config_loader_if.slave  cfg,
  output logic [NUM_PE-1:0]  pe_load,
  output logic [3:0]         pe_instruction,
  output logic [31:0]        pe_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               err_clr
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  cfg_state_e        state_reg;
  logic [3:0]        instr_reg;
  logic [7:0]        first_reg;
  logic [7:0]        count_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [7:0]        remaining_reg;
  logic              bcast_reg;
  logic [NUM_PE-1:0] pe_load_reg;
  logic [3:0]        pe_instruction_reg;
  logic [31:0]       pe_data_reg;
  logic              done_reg;
  logic              err_reg;

  cfg_hdr_t          hdr;
  logic              xfer;
  logic              range_err;
  logic [NUM_PE-1:0] load_mask;
  logic              unused_hdr_bits;

  assign hdr             = hdr_decode(cfg.data);
  assign unused_hdr_bits = ^{hdr.rsvd_hi, hdr.rsvd_lo};
  assign cfg.ready       = ~reset;
  assign xfer            = cfg.valid & cfg.ready;
  // Nine-bit sum so first+count cannot wrap past the PE count
  assign range_err       = (({1'b0, hdr.first} + {1'b0, hdr.count}) > 9'(NUM_PE));

  pe_load_decoder #(.NUM_PE(NUM_PE), .IDX_W(IDX_W)) u_decoder (
    .idx   (idx_reg),
    .first (first_reg),
    .count (count_reg),
    .bcast (bcast_reg),
    .mask  (load_mask)
  );

  assign pe_load        = pe_load_reg;
  assign pe_instruction = pe_instruction_reg;
  assign pe_data        = pe_data_reg;
  assign busy           = (state_reg != HDR);
  assign done           = done_reg;
  assign err            = err_reg;

  // Packet FSM with registered strobes, done pulse and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= HDR;
      instr_reg          <= '0;
      first_reg          <= '0;
      count_reg          <= '0;
      idx_reg            <= '0;
      remaining_reg      <= '0;
      bcast_reg          <= 1'b0;
      pe_load_reg        <= '0;
      pe_instruction_reg <= '0;
      pe_data_reg        <= '0;
      done_reg           <= 1'b0;
      err_reg            <= 1'b0;
    end else begin
      pe_load_reg <= '0;
      done_reg    <= 1'b0;
      // Clear first; any error event later in this block overrides it
      if (err_clr) err_reg <= 1'b0;

      case (state_reg)
        HDR: begin
          if (xfer) begin
            instr_reg     <= hdr.instr;
            first_reg     <= hdr.first;
            count_reg     <= hdr.count;
            idx_reg       <= hdr.first[IDX_W-1:0];
            remaining_reg <= hdr.count;
            bcast_reg     <= 1'b0;
            if (hdr.bcast) begin
`ifdef PE_CFG_BROADCAST_EN
              if ((hdr.count == 8'd0) || range_err || cfg.last) begin
                err_reg   <= 1'b1;
                state_reg <= cfg.last ? HDR : DRAIN;
              end else begin
                bcast_reg     <= 1'b1;
                remaining_reg <= 8'd1;
                state_reg     <= LOAD;
              end
`else
              err_reg   <= 1'b1;
              state_reg <= cfg.last ? HDR : DRAIN;
`endif
            end else if ((hdr.count == 8'd0) && cfg.last) begin
              done_reg <= 1'b1;
            end else if (range_err || (hdr.count == 8'd0)) begin
              err_reg   <= 1'b1;
              state_reg <= cfg.last ? HDR : DRAIN;
            end else if (cfg.last) begin
              err_reg <= 1'b1;
            end else begin
              state_reg <= LOAD;
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            pe_load_reg        <= load_mask;
            pe_data_reg        <= cfg.data;
            pe_instruction_reg <= instr_reg;
            idx_reg            <= idx_reg + IDX_W'(1);
            remaining_reg      <= remaining_reg - 8'd1;
            if (remaining_reg == 8'd1) begin
              if (cfg.last) begin
                done_reg  <= 1'b1;
                state_reg <= HDR;
              end else begin
                err_reg   <= 1'b1;
                state_reg <= DRAIN;
              end
            end else if (cfg.last) begin
              err_reg   <= 1'b1;
              state_reg <= HDR;
            end
          end
        end

        DRAIN: begin
          if (xfer && cfg.last) state_reg <= HDR;
        end

        default: state_reg <= HDR;
      endcase
    end
  end

endmodule

// File: doc/pe_config_loader.md
Name: pe_config_loader

Overview:
Switch-side programming engine for the mesh; it is the transmit end of the PE programming interface (load / instruction / internal_data_in).
- Consumes a valid/ready stream of configuration packets, each a header word followed by data words.
- Drives registered per-PE load strobes plus a broadcast instruction/data bus that writes each addressed PE's configuration and internal register.
- One instance per mesh; instantiated beside the switch fabric.

Parameters:
NUM_PE, 16, number of PEs driven; legal range 1..256.
IDX_W, $clog2(NUM_PE) (min 1), PE index width, derived; not overridden.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  packet word valid
cfg_ready  out  1  loader accepts word (transfer = valid & ready)
cfg_data  in  32  packet word
cfg_last  in  1  final word of packet
pe_load  out  NUM_PE  one-hot (or multi-hot, broadcast) load strobe per PE
pe_instruction  out  4  instruction bus to all PEs
pe_data  out  32  internal_data_in bus to all PEs
busy  out  1  packet in progress
done  out  1  one-cycle pulse: packet completed without error
err  out  1  sticky error flag
err_clr  in  1  clears err

Behaviour:
Reset:
- State HDR; cfg_ready=0 during the reset cycle.
- pe_load=0, pe_instruction=0, pe_data=0, busy=0, done=0, err=0.
- Reset mid-packet abandons the packet; no further strobes.

Header word fields:
- [3:0] instr
- [15:8] first PE index
- [23:16] count of PEs
- [31] broadcast flag (see optional feature)
- [30:24] reserved, ignored

State HDR:
- cfg_ready=1.
- On transfer, latch instr, first, count; busy=1 from the next cycle.
- count==0 with cfg_last=1: done pulse, stay in HDR.
- Range error (first+count > NUM_PE, computed 9-bit with no wrap) or count==0 with cfg_last=0: set err, go DRAIN.
- Header with cfg_last=1 and count!=0: set err, stay in HDR.
- Otherwise go LOAD; idx=first, remaining=count.

State LOAD:
- cfg_ready=1.
- Each transfer: next cycle pe_load[idx]=1 for exactly one cycle; pe_data=word; pe_instruction=instr. Latency 1 cycle, registered.
- Then idx+1 and remaining-1.
- Word with remaining==1 and cfg_last=1: done pulse with the final strobe cycle, go HDR.
- cfg_last=1 while remaining>1: that word still loads; set err; go HDR (short packet).
- remaining==1 and cfg_last=0: word loads; set err; go DRAIN (long packet).
- cfg_valid low stalls with no strobe; back-to-back words give back-to-back strobes.

State DRAIN:
- cfg_ready=1; words discarded; no strobes.
- On cfg_last transfer go HDR.

Common rules:
- pe_instruction and pe_data hold their last value when pe_load=0.
- instr 4'b0010 is passed through unchanged; the PE decides whether to keep its configuration.
- busy=0 only in HDR.
- err_clr clears err; if an error event occurs in the same cycle, set wins.

Optional Feature:
PE_CFG_BROADCAST_EN
- Defined: header bit31=1 means the packet carries exactly one data word (count ignored, except count==0 is an error). pe_load is then asserted for all PEs in [first, first+count) in the same cycle with that word. Word-count and cfg_last rules are as in LOAD with an effective count of 1.
- Undefined: header bit31=1 is a header error: err set, go DRAIN (or stay in HDR if cfg_last=1).

Decomposition:
Package pe_cfg_pkg holds:
- typedef cfg_state_e {HDR, LOAD, DRAIN}
- typedef cfg_hdr_t packed struct (bcast, rsvd, count, first, rsvd, instr)
- localparams for field positions
- instruction constants: FADD=4'b0000, FMUL=4'b0001, SYS_FMA=4'b1010, FMA=4'b0011, WEIGHT_ONLY=4'b0010

One sub-module, pe_load_decoder: combinational index/range to NUM_PE strobe mask, covering single index and broadcast range.

Test Plan:
1. Header instr=3, first=2, count=3, then words 0xA,0xB,0xC (last on 0xC), back-to-back -> pe_load bits 2,3,4 on consecutive cycles with pe_data A,B,C, pe_instruction=3, done pulse with bit 4 strobe, err=0.
2. Same packet with cfg_valid toggled 1-0-1 -> strobes only for accepted words, order and values unchanged.
3. first=14, count=3 (NUM_PE=16) followed by 3 words -> err=1, zero strobes, cfg_ready held 1, returns to HDR after last; next valid packet loads correctly.
4. count=4 but cfg_last on the 2nd data word -> 2 strobes, err=1, no done; err_clr clears err next cycle.
5. reset asserted after the 1st of 3 data words -> no further strobes, all outputs 0, next header accepted normally.
6. PE_CFG_BROADCAST_EN defined: bit31=1, first=0, count=16, word 0x3F800000 -> pe_load=16'hFFFF for one cycle, done. Macro undefined: same stimulus -> err=1, no strobes.
